ula_seq: RTL and testbench

- Registered, parametrised successor of the team's 6-bit combinational ULA.
- Keeps the same arithmetic and logic op sets and the Co/zero flags.
- Adds a third op mode: an iterative shift-add multiplier plus a barrel shifter/rotator.
- Results, flags and a start/busy/done handshake are registered, so the block sits directly on the datapath bus behind the control FSM.

---
 rtl/ula_seq_if.sv | 29 ++
 rtl/ula_seq.sv | 216 +++++++++++++++++++++
 tb/tb_ula_seq.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ula_seq_if.sv
// ula_seq_if: operand, control and result bundle between the control FSM
// (master) and the ula_seq datapath block (slave).
interface ula_seq_if #(
    parameter int WIDTH = 6
);
    logic                 start;
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic [1:0]           selModo;
    logic [2:0]           selOp;
    logic                 useAcc;
    logic [2*WIDTH-1:0]   otULA;
    logic                 Co;
    logic                 zero;
    logic                 overflow;
    logic                 busy;
    logic                 done;
    logic                 err;

    modport master (
        output start, A, B, selModo, selOp, useAcc,
        input  otULA, Co, zero, overflow, busy, done, err
    );

    modport slave (
        input  start, A, B, selModo, selOp, useAcc,
        output otULA, Co, zero, overflow, busy, done, err
    );
endinterface

// File: rtl/ula_seq.sv
// ula_seq: registered ULA with arithmetic, logic and shift/rotate modes plus
// an iterative shift-add multiplier. Results, flags and the start/busy/done
// handshake are all registered.
// Optional accumulator (operand A replacement) is enabled by defining the
// macro ULA_ACC_EN; the default build has no accumulator and ignores useAcc.
module ula_seq #(
    parameter int WIDTH = 6
) (
    input  logic     clk,
    input  logic     reset,
    ula_seq_if.slave bus
);
    localparam int RW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]    LAST_STEP = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] WIDTH_V   = WIDTH'(WIDTH);
    localparam logic [WIDTH:0]   ONE       = (WIDTH + 1)'(1);

    typedef enum logic {IDLE, MUL} state_t;

    state_t           state;

    // Multiplier working registers
    logic [RW-1:0]    mcand;
    logic [WIDTH-1:0] mplier;
    logic [RW-1:0]    prod;
    logic [CW-1:0]    count;
    logic [RW-1:0]    prod_next;

    // Registered outputs
    logic [RW-1:0]    result_q;
    logic             co_q;
    logic             zero_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;

    // Single-cycle datapath
    logic [WIDTH-1:0] op_a;
    logic [WIDTH:0]   a1;
    logic [WIDTH:0]   b1;
    logic [WIDTH:0]   nb1;
    logic [WIDTH:0]   arith;
    logic [WIDTH-1:0] logic_r;
    logic [WIDTH-1:0] shift_r;
    logic [WIDTH-1:0] rot_amt;
    logic [RW-1:0]    comb_res;
    logic             comb_co;
    logic             comb_err;
    logic             is_mul;

`ifdef ULA_ACC_EN
    logic [WIDTH-1:0] acc;
    logic             acc_load;
    logic [WIDTH-1:0] acc_data;

    assign op_a = bus.useAcc ? acc : bus.A;
`else
    logic unused_use_acc;

    assign unused_use_acc = bus.useAcc;
    assign op_a           = bus.A;
`endif

    assign bus.otULA    = result_q;
    assign bus.Co       = co_q;
    assign bus.zero     = zero_q;
    assign bus.overflow = 1'b0;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;

    // One shift-add step: add the shifted multiplicand when the current multiplier LSB is set
    always_comb begin
        prod_next = prod + (mplier[0] ? mcand : '0);
    end

    // Decode the requested operation and compute its single-cycle result
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        a1       = {1'b0, op_a};
        b1       = {1'b0, bus.B};
        nb1      = {1'b0, ~bus.B};
        arith    = '0;
        logic_r  = '0;
        shift_r  = '0;
        rot_amt  = bus.B % WIDTH_V;
        comb_res = '0;
        comb_co  = 1'b0;
        comb_err = 1'b0;
        is_mul   = 1'b0;

        case (bus.selModo)
            2'd0: begin
                case (bus.selOp)
                    3'b000:  arith = a1 + b1;
                    3'b001:  arith = a1 - b1;
                    3'b010:  arith = a1 + nb1;
                    3'b011:  arith = a1 - nb1;
                    3'b100:  arith = a1 + ONE;
                    3'b101:  arith = a1 - ONE;
                    3'b110:  arith = b1 + ONE;
                    default: arith = b1 - ONE;
                endcase
                comb_res = RW'(arith);
                comb_co  = arith[WIDTH];
            end
            2'd1: begin
                case (bus.selOp)
                    3'b000:  logic_r = op_a & bus.B;
                    3'b001:  logic_r = ~op_a;
                    3'b010:  logic_r = ~bus.B;
                    3'b011:  logic_r = op_a | bus.B;
                    3'b100:  logic_r = op_a ^ bus.B;
                    3'b101:  logic_r = ~(op_a & bus.B);
                    3'b110:  logic_r = op_a;
                    default: logic_r = bus.B;
                endcase
                comb_res = RW'(logic_r);
            end
            2'd2: begin
                // Shifts by >= WIDTH naturally yield 0 (logical) or sign fill (arithmetic)
                case (bus.selOp)
                    3'b000:  is_mul   = 1'b1;
                    3'b001:  shift_r  = op_a << bus.B;
                    3'b010:  shift_r  = op_a >> bus.B;
                    3'b011:  shift_r  = $signed(op_a) >>> bus.B;
                    3'b100:  shift_r  = (op_a << rot_amt) | (op_a >> (WIDTH_V - rot_amt));
                    3'b101:  shift_r  = (op_a >> rot_amt) | (op_a << (WIDTH_V - rot_amt));
                    default: comb_err = 1'b1;
                endcase
                comb_res = comb_err ? '0 : RW'(shift_r);
            end
            default: comb_err = 1'b1;
        endcase
    end

    // Handshake FSM, multiplier iteration and registered results/flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            mcand    <= '0;
            mplier   <= '0;
            prod     <= '0;
            count    <= '0;
            result_q <= '0;
            co_q     <= 1'b0;
            zero_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (is_mul) begin
                            mcand  <= RW'(op_a);
                            mplier <= bus.B;
                            prod   <= '0;
                            count  <= '0;
                            busy_q <= 1'b1;
                            state  <= MUL;
                        end else begin
                            result_q <= comb_res;
                            co_q     <= comb_co;
                            zero_q   <= !comb_err && (comb_res == '0);
                            err_q    <= comb_err;
                            done_q   <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    prod   <= prod_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + 1'b1;
                    if (count == LAST_STEP) begin
                        result_q <= prod_next;
                        co_q     <= 1'b0;
                        zero_q   <= (prod_next == '0);
                        err_q    <= 1'b0;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ULA_ACC_EN
    // Accumulator load on every non-reserved completion
    always_comb begin
        acc_load = 1'b0;
        acc_data = comb_res[WIDTH-1:0];
        if (state == MUL) begin
            acc_load = (count == LAST_STEP);
            acc_data = prod_next[WIDTH-1:0];
        end else begin
            acc_load = bus.start && !is_mul && !comb_err;
        end
    end

    // Accumulator register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
        end else if (acc_load) begin
            acc <= acc_data;
        end
    end
`endif
endmodule

// File: tb/tb_ula_seq.sv
// tb_ula_seq: directed self-checking bench for ula_seq (WIDTH=6).
module tb_ula_seq;
    localparam int WIDTH = 6;

    typedef struct {
        logic [1:0]  modo;
        logic [2:0]  op;
        logic [5:0]  a;
        logic [5:0]  b;
        logic [11:0] res;
        logic        co;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    ula_seq_if #(.WIDTH(WIDTH)) bus ();

    ula_seq #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Present one request for exactly one accepting edge; returns at the next falling edge.
    task automatic issue(input logic [1:0] modo, input logic [2:0] op,
                         input logic [5:0] a, input logic [5:0] b);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.selModo = modo;
        bus.selOp   = op;
        bus.A       = a;
        bus.B       = b;
        @(negedge clk);
        bus.start   = 1'b0;
    endtask

    task automatic test_reset;
        // Reset held from time 0
        #3;
        checks++;
        if ({bus.otULA, bus.Co, bus.zero, bus.busy, bus.done, bus.err, bus.overflow} !== 18'd0) begin
            errors++;
            $display("FAIL reset_init got %h exp 0", {bus.otULA, bus.Co, bus.zero, bus.busy, bus.done, bus.err});
        end
        @(negedge clk);
        reset = 1'b0;
        // Load nonzero state, then assert reset mid-cycle
        issue(2'd0, 3'b000, 6'd63, 6'd1);
        checks++;
        if (bus.otULA !== 12'd64 || bus.done !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre got %0d done %b exp 64 done 1", bus.otULA, bus.done);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({bus.otULA, bus.Co, bus.zero, bus.busy, bus.done, bus.err} !== 17'd0) begin
            errors++;
            $display("FAIL reset_async got %h exp 0", {bus.otULA, bus.Co, bus.zero, bus.busy, bus.done, bus.err});
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_arith;
        vec_t v [9];
        v = '{
            '{2'd0, 3'b000, 6'd63, 6'd1,  12'd64,  1'b1},
            '{2'd0, 3'b001, 6'd5,  6'd5,  12'd0,   1'b0},
            '{2'd0, 3'b001, 6'd3,  6'd5,  12'd126, 1'b1},
            '{2'd0, 3'b010, 6'd5,  6'd5,  12'd63,  1'b0},
            '{2'd0, 3'b011, 6'd5,  6'd5,  12'd75,  1'b1},
            '{2'd0, 3'b100, 6'd63, 6'd0,  12'd64,  1'b1},
            '{2'd0, 3'b101, 6'd0,  6'd0,  12'd127, 1'b1},
            '{2'd0, 3'b110, 6'd0,  6'd10, 12'd11,  1'b0},
            '{2'd0, 3'b111, 6'd0,  6'd0,  12'd127, 1'b1}
        };
        foreach (v[i]) begin
            issue(v[i].modo, v[i].op, v[i].a, v[i].b);
            checks++;
            if (bus.otULA !== v[i].res || bus.Co !== v[i].co || bus.zero !== (v[i].res == 12'd0) ||
                bus.done !== 1'b1 || bus.err !== 1'b0) begin
                errors++;
                $display("FAIL arith[%0d] got res %0d co %b z %b done %b exp res %0d co %b",
                         i, bus.otULA, bus.Co, bus.zero, bus.done, v[i].res, v[i].co);
            end
            @(negedge clk);
            checks++;
            if (bus.done !== 1'b0 || bus.otULA !== v[i].res) begin
                errors++;
                $display("FAIL arith_hold[%0d] got done %b res %0d exp done 0 res %0d",
                         i, bus.done, bus.otULA, v[i].res);
            end
        end
    endtask

    task automatic test_logic;
        vec_t v [9];
        v = '{
            '{2'd1, 3'b000, 6'd42, 6'd15, 12'd10, 1'b0},
            '{2'd1, 3'b001, 6'd42, 6'd15, 12'd21, 1'b0},
            '{2'd1, 3'b010, 6'd42, 6'd15, 12'd48, 1'b0},
            '{2'd1, 3'b011, 6'd42, 6'd15, 12'd47, 1'b0},
            '{2'd1, 3'b100, 6'd42, 6'd15, 12'd37, 1'b0},
            '{2'd1, 3'b101, 6'd42, 6'd15, 12'd53, 1'b0},
            '{2'd1, 3'b110, 6'd42, 6'd15, 12'd42, 1'b0},
            '{2'd1, 3'b111, 6'd42, 6'd15, 12'd15, 1'b0},
            '{2'd1, 3'b000, 6'd42, 6'd21, 12'd0,  1'b0}
        };
        foreach (v[i]) begin
            issue(v[i].modo, v[i].op, v[i].a, v[i].b);
            checks++;
            if (bus.otULA !== v[i].res || bus.Co !== 1'b0 || bus.zero !== (v[i].res == 12'd0) ||
                bus.done !== 1'b1 || bus.err !== 1'b0) begin
                errors++;
                $display("FAIL logic[%0d] got res %0d co %b z %b done %b exp res %0d",
                         i, bus.otULA, bus.Co, bus.zero, bus.done, v[i].res);
            end
        end
    endtask

    task automatic test_shift;
        vec_t v [10];
        v = '{
            '{2'd2, 3'b011, 6'd32, 6'd2, 12'd56, 1'b0},
            '{2'd2, 3'b100, 6'd1,  6'd9, 12'd8,  1'b0},
            '{2'd2, 3'b001, 6'd5,  6'd7, 12'd0,  1'b0},
            '{2'd2, 3'b010, 6'd48, 6'd4, 12'd3,  1'b0},
            '{2'd2, 3'b101, 6'd1,  6'd1, 12'd32, 1'b0},
            '{2'd2, 3'b011, 6'd32, 6'd6, 12'd63, 1'b0},
            '{2'd2, 3'b011, 6'd16, 6'd1, 12'd8,  1'b0},
            '{2'd2, 3'b001, 6'd5,  6'd2, 12'd20, 1'b0},
            '{2'd2, 3'b101, 6'd5,  6'd6, 12'd5,  1'b0},
            '{2'd2, 3'b100, 6'd33, 6'd1, 12'd3,  1'b0}
        };
        foreach (v[i]) begin
            issue(v[i].modo, v[i].op, v[i].a, v[i].b);
            checks++;
            if (bus.otULA !== v[i].res || bus.Co !== 1'b0 || bus.zero !== (v[i].res == 12'd0) ||
                bus.done !== 1'b1 || bus.err !== 1'b0) begin
                errors++;
                $display("FAIL shift[%0d] got res %0d co %b z %b done %b exp res %0d",
                         i, bus.otULA, bus.Co, bus.zero, bus.done, v[i].res);
            end
        end
    endtask

    task automatic test_multiply;
        issue(2'd2, 3'b000, 6'd63, 6'd63);
        checks++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL mul_accept got busy %b done %b exp busy 1 done 0", bus.busy, bus.done);
        end
        for (int i = 1; i <= WIDTH; i++) begin
            @(negedge clk);
            if (i == 2) begin
                // Attempted start with different operands while busy
                bus.start   = 1'b1;
                bus.selModo = 2'd0;
                bus.selOp   = 3'b000;
                bus.A       = 6'd1;
                bus.B       = 6'd1;
            end
            if (i == 4) bus.start = 1'b0;
            if (i < WIDTH) begin
                checks++;
                if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
                    errors++;
                    $display("FAIL mul_busy[%0d] got busy %b done %b exp busy 1 done 0", i, bus.busy, bus.done);
                end
            end
        end
        checks++;
        if (bus.otULA !== 12'd3969 || bus.busy !== 1'b0 || bus.done !== 1'b1 ||
            bus.Co !== 1'b0 || bus.zero !== 1'b0 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL mul_done got res %0d busy %b done %b co %b z %b exp res 3969 busy 0 done 1",
                     bus.otULA, bus.busy, bus.done, bus.Co, bus.zero);
        end
        // New request in the done cycle is accepted
        bus.start   = 1'b1;
        bus.selModo = 2'd0;
        bus.selOp   = 3'b000;
        bus.A       = 6'd2;
        bus.B       = 6'd3;
        @(negedge clk);
        bus.start = 1'b0;
        checks++;
        if (bus.otULA !== 12'd5 || bus.done !== 1'b1) begin
            errors++;
            $display("FAIL mul_done_start got res %0d done %b exp 5 done 1", bus.otULA, bus.done);
        end
        // Small product with zero operand
        issue(2'd2, 3'b000, 6'd0, 6'd45);
        for (int i = 1; i <= WIDTH; i++) @(negedge clk);
        checks++;
        if (bus.otULA !== 12'd0 || bus.zero !== 1'b1 || bus.done !== 1'b1) begin
            errors++;
            $display("FAIL mul_zero got res %0d z %b done %b exp 0 z 1 done 1", bus.otULA, bus.zero, bus.done);
        end
    endtask

    task automatic test_reserved;
        issue(2'd0, 3'b000, 6'd10, 6'd20);
        issue(2'd3, 3'b000, 6'd5, 6'd5);
        checks++;
        if (bus.err !== 1'b1 || bus.otULA !== 12'd0 || bus.zero !== 1'b0 ||
            bus.Co !== 1'b0 || bus.done !== 1'b1) begin
            errors++;
            $display("FAIL rsv_mode got err %b res %0d z %b co %b done %b exp err 1 res 0 z 0",
                     bus.err, bus.otULA, bus.zero, bus.Co, bus.done);
        end
        issue(2'd2, 3'b110, 6'd5, 6'd5);
        checks++;
        if (bus.err !== 1'b1 || bus.otULA !== 12'd0 || bus.done !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL rsv_op got err %b res %0d done %b busy %b exp err 1 res 0 done 1",
                     bus.err, bus.otULA, bus.done, bus.busy);
        end
        issue(2'd0, 3'b000, 6'd1, 6'd1);
        checks++;
        if (bus.err !== 1'b0 || bus.otULA !== 12'd2) begin
            errors++;
            $display("FAIL rsv_clear got err %b res %0d exp err 0 res 2", bus.err, bus.otULA);
        end
    endtask

    task automatic test_abort;
        bit saw_done;
        issue(2'd2, 3'b000, 6'd7, 6'd9);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.otULA !== 12'd0) begin
            errors++;
            $display("FAIL abort got busy %b done %b res %0d exp 0 0 0", bus.busy, bus.done, bus.otULA);
        end
        @(negedge clk);
        reset    = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 2 * WIDTH; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_done got done/busy activity %b exp 0", saw_done);
        end
    endtask

    task automatic test_back_to_back;
        vec_t v [3];
        v = '{
            '{2'd0, 3'b000, 6'd10, 6'd20, 12'd30, 1'b0},
            '{2'd1, 3'b100, 6'd63, 6'd7,  12'd56, 1'b0},
            '{2'd2, 3'b001, 6'd3,  6'd4,  12'd48, 1'b0}
        };
        @(negedge clk);
        foreach (v[i]) begin
            bus.start   = 1'b1;
            bus.selModo = v[i].modo;
            bus.selOp   = v[i].op;
            bus.A       = v[i].a;
            bus.B       = v[i].b;
            @(negedge clk);
            checks++;
            if (bus.otULA !== v[i].res || bus.done !== 1'b1) begin
                errors++;
                $display("FAIL b2b[%0d] got res %0d done %b exp res %0d done 1",
                         i, bus.otULA, bus.done, v[i].res);
            end
        end
        bus.start = 1'b0;
    endtask

    task automatic test_acc;
        logic [11:0] exp_res;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset      = 1'b0;
        bus.useAcc = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            issue(2'd0, 3'b100, 6'd0, 6'd0);
`ifdef ULA_ACC_EN
            exp_res = 12'(k);
`else
            exp_res = 12'd1;
`endif
            checks++;
            if (bus.otULA !== exp_res || bus.done !== 1'b1) begin
                errors++;
                $display("FAIL acc[%0d] got res %0d done %b exp %0d", k, bus.otULA, bus.done, exp_res);
            end
        end
        bus.useAcc = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.A       = '0;
        bus.B       = '0;
        bus.selModo = '0;
        bus.selOp   = '0;
        bus.useAcc  = 1'b0;

        test_reset();
        test_arith();
        test_logic();
        test_shift();
        test_multiply();
        test_reserved();
        test_abort();
        test_back_to_back();
        test_acc();

        checks++;
        if (bus.overflow !== 1'b0) begin
            errors++;
            $display("FAIL overflow got %b exp 0", bus.overflow);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
